// File: rtl/vector_dispatch_if.sv
// Handshake bundle for vector_dispatch: packed-vector input pulse plus the
// valid/ready output channel and status flags.
interface vector_dispatch_if #(
    parameter int unsigned VEC_SIZE  = 8,
    parameter int unsigned VEC_WIDTH = 32
);
    logic [VEC_SIZE*VEC_WIDTH-1:0] vec_i;
    logic                          vec_valid_i;
    logic [VEC_SIZE*VEC_WIDTH-1:0] out_data_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          full_o;
    logic                          overflow_o;

    modport slave (
        input  vec_i, vec_valid_i, out_ready_i,
        output out_data_o, out_valid_o, full_o, overflow_o
    );

    modport master (
        output vec_i, vec_valid_i, out_ready_i,
        input  out_data_o, out_valid_o, full_o, overflow_o
    );
endinterface

// File: rtl/vector_dispatch.sv
// Two-entry elastic buffer between the packing stage and the compute array.
// Optional VECTOR_DISPATCH_STATS_EN adds accepted/dropped vector counters.
module vector_dispatch #(
    parameter int unsigned VEC_SIZE  = 8,
    parameter int unsigned VEC_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    vector_dispatch_if.slave   bus
`ifdef VECTOR_DISPATCH_STATS_EN
    ,
    output logic [15:0]        vec_cnt_o,
    output logic [7:0]         drop_cnt_o
`endif
);
    localparam int unsigned W = VEC_SIZE * VEC_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   mem_q [2];
    logic           wp_q, rp_q;
    logic           ovf_q;
    logic           push, pop, accept, drop;

    assign push            = bus.vec_valid_i;
    assign bus.out_valid_o = (state_q != EMPTY);
    assign pop             = bus.out_valid_o & bus.out_ready_i;
    assign bus.out_data_o  = mem_q[rp_q];
    assign bus.full_o      = (state_q == FULL);
    assign bus.overflow_o  = ovf_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    accept  = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                accept = push;
                if (push && !pop) begin
                    state_d = FULL;
                end else if (!push && pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // A pop frees the read slot, which is exactly where wp points.
                if (pop) begin
                    accept = push;
                    if (!push) begin
                        state_d = ONE;
                    end
                end else begin
                    drop = push;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_q[wp_q] <= bus.vec_i;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef VECTOR_DISPATCH_STATS_EN
    logic [15:0] vec_cnt_q;
    logic [7:0]  drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign vec_cnt_o  = vec_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_vector_dispatch.sv
// Scoreboard bench for vector_dispatch: stimulus queues expected vectors,
// a negedge monitor compares every handshake and checks stall stability.
module tb_vector_dispatch;
    localparam int unsigned VS = 8;
    localparam int unsigned VW = 32;
    localparam int unsigned W  = VS * VW;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [W-1:0] sb [$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    vector_dispatch_if #(.VEC_SIZE(VS), .VEC_WIDTH(VW)) bus ();

`ifdef VECTOR_DISPATCH_STATS_EN
    logic [15:0] vec_cnt;
    logic [7:0]  drop_cnt;
`endif

    vector_dispatch #(.VEC_SIZE(VS), .VEC_WIDTH(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef VECTOR_DISPATCH_STATS_EN
        ,
        .vec_cnt_o  (vec_cnt),
        .drop_cnt_o (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v, input bit exp_accept);
        bus.vec_i       = v;
        bus.vec_valid_i = 1'b1;
        if (exp_accept) sb.push_back(v);
        tick();
        bus.vec_valid_i = 1'b0;
    endtask

    function automatic logic [W-1:0] fill(input logic [7:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [W-1:0] tvec(input int k);
        logic [W-1:0] r;
        for (int j = 0; j < VS; j++) r[j*VW +: VW] = 32'((k << 8) | j | 32'hC0DE0000);
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, W'(bus.out_valid_o), W'(0));
        check({tag, "_full"},  W'(bus.full_o),      W'(0));
        check({tag, "_ovf"},   W'(bus.overflow_o),  W'(0));
        check({tag, "_data"},  bus.out_data_o,      '0);
    endtask

    // Monitor: compares each accepted head vector and stall-hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid_o)
                check("stall_hold", bus.out_data_o, prev_data);
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_pop: got %h expected no valid", bus.out_data_o);
                end else begin
                    check("pop_data", bus.out_data_o, sb.pop_front());
                end
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_data  = bus.out_data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] pat, va, vb, vc, vd;
        va = fill(8'hAA);
        vb = fill(8'hBB);
        vc = fill(8'hCC);
        vd = fill(8'hDD);
        for (int k = 0; k < W / 8; k++) pat[k*8 +: 8] = 8'((k % VS) == 0 ? 0 : 0);
        for (int k = 0; k < VS; k++) pat[k*VW +: VW] = 32'(k + 1);

        rst_n           = 1'b0;
        bus.vec_i       = '0;
        bus.vec_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;

        repeat (3) begin
            tick();
            check_idle("reset");
        end

        // Single pass
        rst_n           = 1'b1;
        bus.out_ready_i = 1'b1;
        push(pat, 1'b1);
        check("pass_valid", W'(bus.out_valid_o), W'(1));
        check("pass_data", bus.out_data_o, pat);
        tick();
        check("pass_empty", W'(bus.out_valid_o), W'(0));

        // Stall to FULL, then overflow
        bus.out_ready_i = 1'b0;
        push(va, 1'b1);
        push(vb, 1'b1);
        check("stall_full", W'(bus.full_o), W'(1));
        check("stall_head", bus.out_data_o, va);
        push(vc, 1'b0);
        check("ovf_set", W'(bus.overflow_o), W'(1));
        check("ovf_full", W'(bus.full_o), W'(1));
        check("ovf_head", bus.out_data_o, va);
`ifdef VECTOR_DISPATCH_STATS_EN
        check("drop_cnt", W'(drop_cnt), W'(1));
        check("vec_cnt", W'(vec_cnt), W'(3));
`endif
        repeat (3) tick();
        check("ovf_sticky", W'(bus.overflow_o), W'(1));

        // Drain FULL -> ONE -> EMPTY
        bus.out_ready_i = 1'b1;
        tick();
        check("drain_one_full", W'(bus.full_o), W'(0));
        check("drain_one_valid", W'(bus.out_valid_o), W'(1));
        check("drain_one_head", bus.out_data_o, vb);
        tick();
        check("drain_empty", W'(bus.out_valid_o), W'(0));
        check("drain_ovf", W'(bus.overflow_o), W'(1));
        bus.out_ready_i = 1'b0;

        // Reset mid-operation with a coincident push
        push(fill(8'h11), 1'b1);
        push(fill(8'h22), 1'b1);
        check("mid_full", W'(bus.full_o), W'(1));
        rst_n           = 1'b0;
        bus.vec_i       = fill(8'h33);
        bus.vec_valid_i = 1'b1;
        tick();
        rst_n           = 1'b1;
        bus.vec_valid_i = 1'b0;
        sb.delete();
        check_idle("midrst");
        bus.out_ready_i = 1'b1;
        repeat (4) tick();
        check("midrst_nothing", W'(bus.out_valid_o), W'(0));
        bus.out_ready_i = 1'b0;

        // Push and pop together in FULL
        push(va, 1'b1);
        push(vb, 1'b1);
        check("pp_full_pre", W'(bus.full_o), W'(1));
        bus.out_ready_i = 1'b1;
        push(vd, 1'b1);
        check("pp_full", W'(bus.full_o), W'(1));
        check("pp_ovf", W'(bus.overflow_o), W'(0));
        check("pp_head", bus.out_data_o, vb);
        tick();
        check("pp_next", bus.out_data_o, vd);
        tick();
        check("pp_empty", W'(bus.out_valid_o), W'(0));

        // Throughput: one push per 8 cycles, random ready, forced high at window end
        for (int k = 0; k < 20; k++) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            push(tvec(k), 1'b1);
            for (int c = 1; c < 7; c++) begin
                bus.out_ready_i = 1'($urandom_range(0, 1));
                tick();
            end
            bus.out_ready_i = 1'b1;
            tick();
        end
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check("tp_drained", W'(sb.size()), W'(0));
        check("tp_no_drop", W'(bus.overflow_o), W'(0));
        check("tp_idle", W'(bus.out_valid_o), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
